regfile_shadow: RTL and testbench

REGFILE_SHADOW -- requirements
Module: regfile_shadow

---
 rtl/regfile_shadow.sv | 100 ++++++++++
 tb/tb_regfile_shadow.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_shadow.sv
// rtl/regfile_shadow.sv - register file with shadow bank save/restore sequencer; RF_BYPASS_EN enables write-to-read forwarding
module regfile_shadow #(
  parameter int W  = 8,
  parameter int D  = 4,
  parameter int NR = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            WriteEn,
  input  logic [D-1:0]    Waddr,
  input  logic [W-1:0]    DataIn,
  input  logic [NR*D-1:0] Raddr,
  output logic [NR*W-1:0] DataOut,
  input  logic            SaveReq,
  input  logic            RestoreReq,
  output logic            Busy,
  output logic            Done
);

  localparam int N = 2 ** D;

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

  state_t       state, state_nx;
  logic [D-1:0] idx, idx_nx;
  logic [W-1:0] main_q   [N];
  logic [W-1:0] shadow_q [N];
  logic         wr_ok;

  // External writes are locked out while the main bank is being restored
  assign wr_ok = WriteEn && (state != RESTORE);

  // State and copy index register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Next-state logic: SAVE wins over RESTORE, requests outside IDLE are dropped
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        if (SaveReq) begin
          state_nx = SAVE;
          idx_nx   = '0;
        end else if (RestoreReq) begin
          state_nx = RESTORE;
          idx_nx   = '0;
        end
      end
      SAVE, RESTORE: begin
        idx_nx = idx + 1'b1;
        if (&idx) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign Busy = (state == SAVE) || (state == RESTORE);
  assign Done = (state == DONE);

  // Main bank: restore copy has priority, otherwise accept external writes
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < N; i++) main_q[i] <= '0;
    end else if (state == RESTORE) begin
      main_q[idx] <= shadow_q[idx];
    end else if (wr_ok) begin
      main_q[Waddr] <= DataIn;
    end
  end

  // Shadow bank: only written by the save copy; reads pre-write main contents
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < N; i++) shadow_q[i] <= '0;
    end else if (state == SAVE) begin
      shadow_q[idx] <= main_q[idx];
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [D-1:0] ra;
    assign ra = Raddr[k*D +: D];
`ifdef RF_BYPASS_EN
    assign DataOut[k*W +: W] = (wr_ok && Reset && (ra == Waddr)) ? DataIn : main_q[ra];
`else
    assign DataOut[k*W +: W] = main_q[ra];
`endif
  end

endmodule

// File: tb/tb_regfile_shadow.sv
// tb/tb_regfile_shadow.sv - scoreboard bench for regfile_shadow
module tb_regfile_shadow;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int NR = 2;
  localparam int N  = 16;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            WriteEn = 1'b0;
  logic [D-1:0]    Waddr = '0;
  logic [W-1:0]    DataIn = '0;
  logic [NR*D-1:0] Raddr = '0;
  logic [NR*W-1:0] DataOut;
  logic            SaveReq = 1'b0;
  logic            RestoreReq = 1'b0;
  logic            Busy;
  logic            Done;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]    m_main   [N];
  logic [W-1:0]    m_shadow [N];
  logic [NR*W-1:0] exp_q [$];

  always #5 Clk = ~Clk;

  regfile_shadow #(.W(W), .D(D), .NR(NR)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .WriteEn(WriteEn),
    .Waddr(Waddr),
    .DataIn(DataIn),
    .Raddr(Raddr),
    .DataOut(DataOut),
    .SaveReq(SaveReq),
    .RestoreReq(RestoreReq),
    .Busy(Busy),
    .Done(Done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [W-1:0] exp_rd(input logic [D-1:0] a);
    logic [W-1:0] v;
    v = m_main[a];
`ifdef RF_BYPASS_EN
    if (WriteEn && (Waddr == a)) v = DataIn;
`endif
    return v;
  endfunction

  task automatic rd(input string tag, input logic [D-1:0] a0, input logic [D-1:0] a1);
    logic [NR*W-1:0] e;
    Raddr = {a1, a0};
    exp_q.push_back({exp_rd(a1), exp_rd(a0)});
    #1;
    e = exp_q.pop_front();
    check(tag, 32'(DataOut), 32'(e));
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < N / 2; i++) begin
      rd(tag, D'(i), D'(i + N / 2));
      tick;
    end
  endtask

  task automatic wr(input logic [D-1:0] a, input logic [W-1:0] d);
    WriteEn = 1'b1;
    Waddr   = a;
    DataIn  = d;
    tick;
    WriteEn = 1'b0;
    m_main[a] = d;
  endtask

  task automatic run_copy(input string tag, input bit save, input bit both,
                          input int inj, input logic [D-1:0] wa, input logic [W-1:0] wd);
    SaveReq    = save | both;
    RestoreReq = !save | both;
    tick;
    SaveReq    = 1'b0;
    RestoreReq = 1'b0;
    for (int c = 0; c < N; c++) begin
      check({tag, "_busy"}, 32'(Busy), 32'd1);
      check({tag, "_done_lo"}, 32'(Done), 32'd0);
      if (c == 3) begin
        SaveReq    = !save;
        RestoreReq = save;
      end
      if (c == inj) begin
        WriteEn = 1'b1;
        Waddr   = wa;
        DataIn  = wd;
      end
      if (save) begin
        m_shadow[c] = m_main[c];
        if (c == inj) m_main[wa] = wd;
      end else begin
        m_main[c] = m_shadow[c];
      end
      tick;
      WriteEn    = 1'b0;
      SaveReq    = 1'b0;
      RestoreReq = 1'b0;
    end
    check({tag, "_done"}, 32'(Done), 32'd1);
    check({tag, "_busy_end"}, 32'(Busy), 32'd0);
    tick;
    check({tag, "_done_one"}, 32'(Done), 32'd0);
    check({tag, "_idle"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_main[i]   = '0;
      m_shadow[i] = '0;
    end
    #2;
    Reset = 1'b0;
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    Raddr = {4'd7, 4'd3};
    #1;
    check("rst_data", 32'(DataOut), 32'd0);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b1;
    rd("post_rst", 4'd1, 4'd14);
    tick;

    // save / clear / restore round trip
    for (int i = 0; i < N; i++) wr(D'(i), 8'(8'h11 * i));
    run_copy("save1", 1'b1, 1'b0, -1, '0, '0);
    for (int i = 0; i < N; i++) wr(D'(i), 8'h00);
    read_all("zeroed");
    run_copy("rest1", 1'b0, 1'b0, -1, '0, '0);
    read_all("restored");

    // simultaneous requests take the save path
    for (int i = 0; i < N; i++) wr(D'(i), 8'(i) ^ 8'hA5);
    run_copy("both", 1'b1, 1'b1, -1, '0, '0);
    read_all("both_main");
    for (int i = 0; i < N; i++) wr(D'(i), 8'h00);
    run_copy("both_rest", 1'b0, 1'b0, -1, '0, '0);
    read_all("both_restored");

    // write to the slot being saved: shadow keeps the old value
    for (int i = 0; i < N; i++) wr(D'(i), 8'(8'h11 * i));
    run_copy("save_wr5", 1'b1, 1'b0, 5, 4'd5, 8'hAA);
    read_all("after_wr5");
    for (int i = 0; i < N; i++) wr(D'(i), 8'h00);
    run_copy("rest_wr5", 1'b0, 1'b0, -1, '0, '0);
    read_all("shadow5");

    // external write ignored during restore
    run_copy("rest_wr3", 1'b0, 1'b0, 1, 4'd3, 8'h7E);
    rd("rest_no7e", 4'd3, 4'd5);
    tick;

    // same-cycle read of a location being written
    wr(4'd2, 8'h55);
    WriteEn = 1'b1;
    Waddr   = 4'd2;
    DataIn  = 8'h3C;
    rd("bypass", 4'd2, 4'd6);
    tick;
    WriteEn = 1'b0;
    m_main[2] = 8'h3C;
    rd("bypass_after", 4'd2, 4'd6);
    tick;

    // asynchronous reset mid-save
    for (int i = 0; i < N; i++) wr(D'(i), 8'(8'h11 * i));
    SaveReq = 1'b1;
    tick;
    SaveReq = 1'b0;
    repeat (8) tick;
    check("mid_busy", 32'(Busy), 32'd1);
    Raddr = {4'd9, 4'd4};
    #1;
    Reset = 1'b0;
    #1;
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    check("abort_data", 32'(DataOut), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick;
      check("abort_hold_done", 32'(Done), 32'd0);
    end
    Reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_main[i]   = '0;
      m_shadow[i] = '0;
    end
    for (int c = 0; c < 3; c++) begin
      tick;
      check("abort_nodone", 32'(Done), 32'd0);
      check("abort_idle", 32'(Busy), 32'd0);
    end
    read_all("abort_zero");
    for (int i = 0; i < N; i++) wr(D'(i), 8'hFF);
    run_copy("abort_rest", 1'b0, 1'b0, -1, '0, '0);
    read_all("abort_shadow0");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
